// File: rtl/prefetch_unit_pkg.sv
// Shared widths, state encoding and helpers for the instruction prefetch unit.
package prefetch_unit_pkg;

  // Address and word widths shared with the rest of the core.
  localparam int RISCV_ADDR_WIDTH = 32;
  localparam int RISCV_WORD_WIDTH = 32;

  // Response FIFO entry: {address tag, instruction word}.
  localparam int FIFO_WIDTH = RISCV_ADDR_WIDTH + RISCV_WORD_WIDTH;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_t;

  // Drop the halfword/byte bits to form the word address sent to memory.
  function automatic logic [RISCV_ADDR_WIDTH-1:0] word_align(input logic [RISCV_ADDR_WIDTH-1:0] a);
    return {a[RISCV_ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/prefetch_unit_fetch_fifo.sv
// Two-entry response FIFO holding {address, word} while the realign buffer is
// busy. Flush wins over push/pop so a redirect always empties it.
module fetch_fifo
  import prefetch_unit_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             pop_ok;
  logic             push_ok;

  // A pop only happens when something is stored; a push into a full FIFO is
  // accepted only when the head leaves in the same cycle.
  always_comb begin
    pop_ok  = pop && (count_q != 2'd0);
    push_ok = push && ((count_q != 2'd2) || pop_ok);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push_ok) - 2'(pop_ok);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: issues word fetches to instruction memory, keeps
// at most two requests in flight, tags each with its address, and feeds the
// realign buffer either directly (zero latency) or through a 2-entry FIFO.
// Branches flush the buffer/FIFO and discard responses already in flight.
//
// Handshake: a request transfers on a cycle with imem_req_o & imem_gnt_i;
// imem_rvalid_i returns one response per cycle in grant order. A buffer write
// transfers on buf_write_en_o and is only driven while buf_full_i is low.
module prefetch_unit
  import prefetch_unit_pkg::*;
#(
  parameter logic [RISCV_ADDR_WIDTH-1:0] BOOT_ADDR       = 32'h0000_0000,
  parameter int                          MAX_OUTSTANDING = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fetch_en_i,
  input  logic                        branch_i,
  input  logic [RISCV_ADDR_WIDTH-1:0] branch_addr_i,
  output logic                        imem_req_o,
  output logic [RISCV_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                        imem_gnt_i,
  input  logic                        imem_rvalid_i,
  input  logic [RISCV_WORD_WIDTH-1:0] imem_rdata_i,
  output logic                        buf_write_en_o,
  output logic [RISCV_WORD_WIDTH-1:0] buf_instr_o,
  output logic [RISCV_ADDR_WIDTH-1:0] buf_addr_o,
  output logic                        buf_clear_o,
  output logic                        buf_read_offset_o,
  input  logic                        buf_full_i,
  output fetch_state_t                dbg_state
);

  localparam logic [2:0] LIMIT = 3'(MAX_OUTSTANDING);

  fetch_state_t                state_q, state_d;
  logic                        first_q;
  logic [RISCV_ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [1:0]                  outs_q, outs_d;
  logic [1:0]                  discard_q, discard_d;
  logic [RISCV_ADDR_WIDTH-1:0] tag_q [2];
  logic                        tag_wr_q, tag_rd_q;

  logic                        branch, rvalid, grant, stale, good_rv;
  logic                        drain, fwd, push;
  logic [FIFO_WIDTH-1:0]       fifo_head;
  logic [1:0]                  fifo_count;
  logic                        fifo_empty;
  logic                        unused_bit0;

  // Bit 0 of the branch target is a halfword-aligned don't-care.
  assign unused_bit0 = branch_addr_i[0];

  // Strobes are ignored while reset is held so outputs stay at their reset values.
  assign branch = branch_i & ~rst;
  assign rvalid = imem_rvalid_i & ~rst & (outs_q != 2'd0);

  // State register, boot-clear flag, fetch address, counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      first_q      <= 1'b1;
      fetch_addr_q <= word_align(BOOT_ADDR);
      outs_q       <= 2'd0;
      discard_q    <= 2'd0;
    end else begin
      state_q      <= state_d;
      if (state_q == ST_FETCH) first_q <= 1'b0;
      fetch_addr_q <= fetch_addr_d;
      outs_q       <= outs_d;
      discard_q    <= discard_d;
    end
  end

  // Address tags for in-flight requests, written on grant, retired on rvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q[0] <= '0;
      tag_q[1] <= '0;
      tag_wr_q <= 1'b0;
      tag_rd_q <= 1'b0;
    end else begin
      if (grant) begin
        tag_q[tag_wr_q] <= fetch_addr_q;
        tag_wr_q        <= ~tag_wr_q;
      end
      if (rvalid) tag_rd_q <= ~tag_rd_q;
    end
  end

  // Next state, request issue, response routing and buffer outputs.
  always_comb begin
    state_d           = state_q;
    imem_req_o        = 1'b0;
    grant             = 1'b0;
    stale             = 1'b0;
    good_rv           = 1'b0;
    drain             = 1'b0;
    fwd               = 1'b0;
    push              = 1'b0;
    fetch_addr_d      = fetch_addr_q;
    outs_d            = outs_q;
    discard_d         = discard_q;
    buf_write_en_o    = 1'b0;
    buf_instr_o       = '0;
    buf_addr_o        = '0;
    buf_clear_o       = 1'b0;
    buf_read_offset_o = BOOT_ADDR[1];

    case (state_q)
      ST_IDLE:  if (fetch_en_i) state_d = ST_FETCH;
      ST_FETCH: if (!fetch_en_i && (outs_q == 2'd0)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Words held in the FIFO count against the in-flight budget so the FIFO
    // can always absorb every outstanding response.
    imem_req_o = (state_q == ST_FETCH) && fetch_en_i &&
                 (({1'b0, outs_q} + {1'b0, fifo_count}) < LIMIT);
    grant      = imem_req_o & imem_gnt_i;

    stale   = (discard_q != 2'd0);
    good_rv = rvalid & ~stale & ~branch;
    drain   = ~branch & ~buf_full_i & ~fifo_empty;
    fwd     = good_rv & ~buf_full_i & fifo_empty;
    push    = good_rv & ~fwd;

    outs_d = outs_q + 2'(grant) - 2'(rvalid);

    if (branch) begin
      fetch_addr_d = word_align(branch_addr_i);
      discard_d    = outs_d;
    end else begin
      if (grant) fetch_addr_d = fetch_addr_q + 32'd4;
      if (rvalid && stale) discard_d = discard_q - 2'd1;
    end

    if (drain) begin
      buf_write_en_o = 1'b1;
      buf_addr_o     = fifo_head[FIFO_WIDTH-1:RISCV_WORD_WIDTH];
      buf_instr_o    = fifo_head[RISCV_WORD_WIDTH-1:0];
    end else if (fwd) begin
      buf_write_en_o = 1'b1;
      buf_addr_o     = tag_q[tag_rd_q];
      buf_instr_o    = imem_rdata_i;
    end

    if (branch) begin
      buf_clear_o       = 1'b1;
      buf_read_offset_o = branch_addr_i[1];
    end else if ((state_q == ST_FETCH) && first_q) begin
      buf_clear_o       = 1'b1;
    end
  end

  fetch_fifo #(.WIDTH(FIFO_WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch),
    .push      (push),
    .push_data ({tag_q[tag_rd_q], imem_rdata_i}),
    .pop       (drain),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign imem_addr_o = fetch_addr_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, first fetch address after reset (bit 0 ignored).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, fixed at 2 for this release.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 fetch_en_i  input  1  permits fetching; low holds unit in IDLE.
REQ-006 branch_i  input  1  redirect strobe, one cycle.
REQ-007 branch_addr_i  input  32  redirect target, halfword aligned.
REQ-008 imem_req_o  output  1  instruction memory request.
REQ-009 imem_addr_o  output  32  request word address, bits [1:0] = 2'b00.
REQ-010 imem_gnt_i  input  1  request accepted this cycle.
REQ-011 imem_rvalid_i  input  1  response data valid; responses in grant order, at least 1 cycle after grant.
REQ-012 imem_rdata_i  input  32  response word.
REQ-013 buf_write_en_o  output  1  write strobe to realign buffer.
REQ-014 buf_instr_o  output  32  word to realign buffer.
REQ-015 buf_addr_o  output  32  word address of buf_instr_o.
REQ-016 buf_clear_o  output  1  flush realign buffer.
REQ-017 buf_read_offset_o  output  1  halfword offset loaded into realign buffer on clear.
REQ-018 buf_full_i  input  1  realign buffer full; no write accepted.

Function
REQ-019 SHALL implement states IDLE and FETCH; IDLE->FETCH when fetch_en_i=1; FETCH->IDLE when fetch_en_i=0 and outstanding=0.
REQ-020 SHALL assert buf_clear_o with buf_read_offset_o=BOOT_ADDR[1] in the first FETCH cycle after reset.
REQ-021 SHALL assert imem_req_o in FETCH while fetch_en_i=1 and (outstanding + fifo_count) < 2.
REQ-022 SHALL increment fetch address by 4 on each cycle imem_req_o & imem_gnt_i, wrapping modulo 2^32.
REQ-023 SHALL track outstanding (0..2): +1 on grant, -1 on rvalid, unchanged on both.
REQ-024 SHALL keep an address tag per outstanding request, emitted as buf_addr_o with its data.
REQ-025 SHALL forward a non-stale rvalid combinationally to buf_write_en_o when FIFO empty and buf_full_i=0 (zero latency).
REQ-026 SHALL push a non-stale rvalid word+address into the 2-entry response FIFO when FIFO non-empty or buf_full_i=1.
REQ-027 SHALL drain FIFO head to the buffer ahead of any new rvalid when buf_full_i=0; one write per cycle max.
REQ-028 SHALL never drop a non-stale word; FIFO overflow is impossible by REQ-021.
REQ-029 On branch_i: SHALL assert buf_clear_o and buf_read_offset_o=branch_addr_i[1] same cycle, suppress buf_write_en_o, flush FIFO, set fetch address to {branch_addr_i[31:2],2'b00}.
REQ-030 On branch_i: SHALL set discard count = outstanding after this cycle's grant/rvalid update; each later rvalid while discard>0 SHALL decrement it and be dropped.
REQ-031 Grant in the branch cycle SHALL carry the old address and count as stale.
REQ-032 Branch while imem_req_o pending ungranted SHALL switch imem_addr_o to the target next cycle.
REQ-033 Branch in IDLE SHALL update fetch address and clear buffer only.
REQ-034 buf_clear_o SHALL be 0 in all other cycles.

Reset
REQ-035 While rst=1: state IDLE, fetch address BOOT_ADDR word-aligned, outstanding=0, discard=0, FIFO empty.
REQ-036 Reset outputs: imem_req_o=0, buf_write_en_o=0, buf_clear_o=0, buf_instr_o=0, buf_addr_o=0, imem_addr_o=BOOT_ADDR&~3.
REQ-037 Reset mid-transaction SHALL abandon in-flight requests; memory side is reset with the core.

Structure
REQ-038 Address/word widths SHALL use RISCV_ADDR_WIDTH and RISCV_WORD_WIDTH from riscv_defines.v; state encodings SHALL live there.
REQ-039 Response FIFO SHALL be sub-module fetch_fifo (2-entry, 64-bit data+address, push/pop/count, flush).

Verification
REQ-040 Reset release, fetch_en_i=1, gnt every cycle, rvalid 1 cycle later -> addresses 0,4,8..., buf_clear_o pulse first cycle, one buffer write per cycle with matching buf_addr_o.
REQ-041 buf_full_i=1 with 2 outstanding -> both words into FIFO, imem_req_o=0; release full -> words written in order, then requests resume.
REQ-042 branch_i to 32'h0000_0102 with 2 outstanding -> buf_clear_o=1, offset=1, next imem_addr_o=32'h100, two stale rvalids dropped, first write buf_addr_o=32'h100.
REQ-043 branch_i same cycle as grant and rvalid -> grant stale, discard=1, no write that cycle.
REQ-044 Fetch address 32'hFFFF_FFFC granted -> next imem_addr_o=32'h0000_0000.
REQ-045 rst asserted with 2 outstanding and FIFO full -> all outputs at REQ-036 values immediately, no writes after release until new responses.
